// File: rtl/disp_digit_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_pkg : shared types and seven-segment constants for digit driver  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package disp_pkg;

  localparam int NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    if (bcd < 4'd10) begin
      seg_encode = SEG_DIGIT[bcd];
    end else begin
      seg_encode = SEG_BLANK;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_digit_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_digit_driver_if : value load handshake and scan/segment bus      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface disp_digit_driver_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] value_in;
  logic             load;
  logic             ready;
  logic [2:0]       a;
  logic [6:0]       seg;
  logic [2:0]       an;
  logic             ovf;

  modport master (
    output value_in, load, a,
    input  ready, seg, an, ovf
  );

  modport slave (
    input  value_in, load, a,
    output ready, seg, an, ovf
  );
endinterface
`default_nettype wire

// File: rtl/disp_digit_driver_bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd_seq : sequential double-dabble converter, one bit per cycle   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic [WIDTH-1:0]        value_i,
  input  wire logic                    load_i,
  output logic                         ready_o,
  output logic [4*NUM_DIGITS-1:0]      bcd_o,
  output logic                         commit_o,
  output logic                         ovf_o
);

  localparam int         SW        = WIDTH + 4 * NUM_DIGITS;
  localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_CONV   = CONV;
  localparam logic [1:0] ST_COMMIT = COMMIT;

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;
  logic [SW-1:0]    adjusted;

  always_comb begin
    adjusted = shift_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (shift_q[WIDTH + 4*i +: 4] >= 4'd5) begin
        adjusted[WIDTH + 4*i +: 4] = shift_q[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          shift_d = {{(4*NUM_DIGITS){1'b0}}, value_i};
          value_d = value_i;
          cnt_d   = 5'd0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        shift_d = {adjusted[SW-2:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Three BCD digits cannot hold the value, so flag it for dashes
        ovf_d   = (32'(value_q) > 32'd999);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= 5'd0;
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign commit_o = (state_q == ST_COMMIT);
  assign bcd_o    = shift_q[WIDTH +: 4*NUM_DIGITS];
  assign ovf_o    = ovf_q;

endmodule
`default_nettype wire

// File: rtl/disp_digit_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_digit_driver : binary to 3-digit seven-segment scan driver       |
// | Optional: DISP_LEAD_ZERO_BLANK_EN blanks leading zero digits           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module disp_digit_driver
  import disp_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input wire logic         clk,
  input wire logic         rst,
  disp_digit_driver_if.slave bus
);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    commit;
  logic                    ovf;
  logic [4*NUM_DIGITS-1:0] disp_q;
  logic [6:0]              seg_q, seg_d;
  logic [2:0]              an_q, an_d;
  logic                    sel_valid;
  logic [1:0]              sel_idx;
  logic [3:0]              nibble;
  logic                    lead_blank;
  logic [6:0]              pattern;

  bin2bcd_seq #(
    .WIDTH (WIDTH)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .value_i  (bus.value_in),
    .load_i   (bus.load),
    .ready_o  (bus.ready),
    .bcd_o    (bcd),
    .commit_o (commit),
    .ovf_o    (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
    end else if (commit) begin
      disp_q <= bcd;
    end
  end

  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (bus.a)
      3'b001:  sel_idx = 2'd0;
      3'b010:  sel_idx = 2'd1;
      3'b100:  sel_idx = 2'd2;
      default: sel_valid = 1'b0;
    endcase
  end

  assign nibble = disp_q[4*sel_idx +: 4];

`ifdef DISP_LEAD_ZERO_BLANK_EN
  assign lead_blank = ((sel_idx == 2'd2) && (disp_q[11:8] == 4'd0)) ||
                      ((sel_idx == 2'd1) && (disp_q[11:4] == 8'd0));
`else
  assign lead_blank = 1'b0;
`endif

  always_comb begin
    if (!sel_valid) begin
      pattern = SEG_BLANK;
    end else if (ovf) begin
      pattern = SEG_DASH;
    end else if (lead_blank) begin
      pattern = SEG_BLANK;
    end else begin
      pattern = seg_encode(nibble);
    end
    // Polarity is applied only here so all internal patterns stay active-high
    seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
    an_d  = sel_valid ? bus.a : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      an_q  <= 3'b000;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.ovf = ovf;

endmodule
`default_nettype wire

// File: doc/disp_digit_driver.md
Name: disp_digit_driver

Overview:
- Downstream stage of the display scan controller.
- Accepts a binary value and converts it to three BCD digits with a sequential double-dabble FSM.
- Holds the converted digits in a display register.
- Produces registered seven-segment and digit-enable outputs, aligned to the controller's one-hot 3-bit digit select `a`.

Parameters:
- WIDTH, 10: bit width of value_in. Valid range 4..16.
- SEG_ACTIVE_LOW, 1: when 1, a lit segment drives 0. When 0, a lit segment drives 1.

Ports:
- clk  in  1  system clock (27 MHz).
- rst  in  1  synchronous, active-high reset.
- value_in  in  WIDTH  unsigned value to display.
- load  in  1  one-cycle strobe; accepted only when ready=1.
- ready  out  1  converter idle; a new load will be accepted.
- a  in  3  one-hot digit select from the scan controller. a[0]=units, a[1]=tens, a[2]=hundreds.
- seg  out  7  segment pattern, bit order {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- an  out  3  registered digit enable (active-high), aligned with seg.
- ovf  out  1  high while the displayed value exceeds 999.

Behaviour:
- Reset values (on any clk edge with rst=1, including mid-conversion):
  - FSM goes to IDLE; any conversion in progress is aborted.
  - ready=1, ovf=0.
  - Display digits = 0,0,0.
  - an=000; seg = all segments off (7'h7F when SEG_ACTIVE_LOW=1).
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: ready=1. On load=1, latch value_in into shift reg = {12'b0, value_in}, clear the iteration counter, go to CONV.
  - CONV: ready=0. Each cycle:
    - add 3 to every BCD nibble >= 5;
    - then shift the whole register left by 1;
    - counter++.
    - After WIDTH iterations, go to COMMIT.
  - COMMIT: ready=0. Write the BCD nibbles to the display register. Set ovf = (latched value > 999). Go to IDLE.
- Latency, with load sampled at edge 0:
  - ready=0 from edge 0 through edge WIDTH+1.
  - Display register updates at edge WIDTH+1 (edge 11 at default WIDTH); ready=1 after that edge.
  - seg reflects the new value on the following edge.
- load while ready=0 is ignored; no queueing. The display keeps its old value until COMMIT.
- Overflow: when ovf=1, every digit displays a dash (segment g only), regardless of the BCD contents.
- Output stage, registered with 1-cycle latency from `a`:
  - a is one-hot: an <= a; seg <= encode(selected digit).
  - a is 000 or has more than one bit set: an <= 000, seg <= all off.
- Digit encodings use the standard 0-9 patterns. The display register and output registers update in the same edge without glitching: seg shows either the old or the new digit, never a mix.

Optional Feature:
- Macro: DISP_LEAD_ZERO_BLANK_EN.
- Defined:
  - the hundreds digit is blanked when it is 0;
  - the tens digit is blanked when hundreds and tens are both 0;
  - the units digit is never blanked;
  - blanking does not apply when ovf=1 (dashes still shown).
- Undefined: all three digits are always shown, including leading zeros.

Decomposition:
- Package disp_pkg:
  - NUM_DIGITS=3;
  - FSM state enum (IDLE, CONV, COMMIT);
  - active-high segment constants SEG_DIGIT[0:9], SEG_DASH, SEG_BLANK;
  - a function seg_encode(bcd nibble) returning the active-high pattern.
  - Polarity inversion is applied once, at the output register.
- Sub-module bin2bcd_seq: owns the FSM, shift register, counter, ready and the overflow flag; outputs the three BCD nibbles plus a commit pulse.
- Top level: display register, digit select mux, encode, output registers.

Test Plan:
- Reset: assert rst for 2 cycles with a=001 -> seg=7'h7F, an=000, ready=1, ovf=0. After release and one edge: an=001, seg=1000000 ("0").
- Conversion: load=1 with value_in=427 -> ready=0 for 11 edges, then 1. Then:
  - a=001 -> seg=1111000 ("7");
  - a=010 -> seg=0100100 ("2");
  - a=100 -> seg=0011001 ("4").
  - an follows a one cycle late in each case.
- Overflow: load value_in=1000 -> after commit ovf=1, and all three digits show seg=0111111. A subsequent load of 5 -> ovf=0 and units shows seg=0010010.
- Busy: load 427, then load 5 three cycles later -> the second load is ignored; display shows 4,2,7 and ready rises exactly 11 edges after the first load.
- Select errors and reset mid-run:
  - a=011 -> next edge seg=1111111, an=000.
  - Asserting rst during CONV -> ready=1 next edge, display digits 0,0,0, no later commit.
- Feature: with DISP_LEAD_ZERO_BLANK_EN defined:
  - load 7 -> hundreds and tens show seg=1111111, units shows 1111000;
  - load 0 -> units shows 1000000.
  - Without the macro, load 7 shows 1000000 on hundreds and tens.
